// File: rtl/display_mux8.sv
// Eight-digit common-anode seven-segment scanner: captures digit writes into a
// small store and time-multiplexes them with a guard interval and leading-zero blanking.
module display_mux8 #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned GUARD    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] display_val,
    input  logic [2:0] display_idx,
    input  logic       display_wr,
    input  logic       clear,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [7:0] an,
    output logic       frame_tick
);

    localparam int unsigned PC_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [PC_W-1:0] PC_GUARD = PC_W'(GUARD);
    localparam logic [6:0] SEG_BLANK   = 7'h7F;

    logic [PC_W-1:0] pc;
    logic [2:0]      scan;
    logic [7:0]      valid;
    logic [3:0]      value [8];
    logic [7:0]      lz_blank;
    logic [6:0]      seg_c;
    logic [7:0]      an_c;
    logic            frame_tick_c;
    logic            slot_end;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_end = (pc == PC_LAST);

    // Refresh prescaler and digit scan position
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc   <= '0;
            scan <= '0;
        end else if (slot_end) begin
            pc   <= '0;
            scan <= scan + 3'd1;
        end else begin
            pc   <= pc + PC_W'(1);
        end
    end

    // Digit store: clear applies first so a same-edge write survives it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            for (int i = 0; i < 8; i++) begin
                value[i] <= '0;
            end
        end else begin
            if (clear) begin
                valid <= '0;
            end
            if (display_wr) begin
                valid[display_idx] <= 1'b1;
                value[display_idx] <= display_val;
            end
        end
    end

    // A zero is blanked while every digit to its left is blank or zero; position 7 always shows
    always_comb begin
        logic run;
        lz_blank = '0;
        run      = 1'b1;
        for (int k = 0; k < 7; k++) begin
            lz_blank[k] = blank_lz && run && valid[k] && (value[k] == 4'd0);
            run         = run && (!valid[k] || (value[k] == 4'd0));
        end
    end

    always_comb begin
        seg_c        = SEG_BLANK;
        an_c         = 8'hFF;
        frame_tick_c = slot_end && (scan == 3'd7);
        if (pc >= PC_GUARD) begin
            an_c = ~(8'(1) << scan);
            if (valid[scan] && !lz_blank[scan]) begin
                seg_c = hex_to_seg(value[scan]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg        <= SEG_BLANK;
            an         <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_c;
            an         <= an_c;
            frame_tick <= frame_tick_c;
        end
    end

endmodule

// File: tb/tb_display_mux8.sv
// Self-checking bench for display_mux8: cycle-count based reference model of the
// digit store, scan timing and blanking rules, directed scenarios plus random traffic.
module tb_display_mux8;

    localparam int unsigned SCAN_DIV = 8;
    localparam int unsigned GUARD    = 2;
    localparam int          FRAME    = 8 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] display_val;
    logic [2:0] display_idx;
    logic       display_wr;
    logic       clear;
    logic       blank_lz;
    logic [6:0] seg;
    logic [7:0] an;
    logic       frame_tick;

    display_mux8 #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
        .clk        (clk),
        .rst        (rst),
        .display_val(display_val),
        .display_idx(display_idx),
        .display_wr (display_wr),
        .clear      (clear),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;
    int t      = 0;
    bit         m_valid [8];
    logic [3:0] m_val   [8];
    logic [6:0] hex_tab [16];
    logic [6:0] obs_slot[8];
    logic [6:0] want    [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
        end
    endtask

    function automatic logic [6:0] exp_digit(input int k, input bit lz);
        bit run;
        if (!m_valid[k]) return 7'h7F;
        if (lz && k != 7 && m_val[k] == 4'd0) begin
            run = 1'b1;
            for (int j = 0; j < k; j++)
                if (m_valid[j] && m_val[j] != 4'd0) run = 1'b0;
            if (run) return 7'h7F;
        end
        return hex_tab[m_val[k]];
    endfunction

    // One clock: predict outputs from the state before the edge, then update the model
    task automatic step();
        int pc, slot;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_ft;
        @(posedge clk);
        pc    = t % SCAN_DIV;
        slot  = (t / SCAN_DIV) % 8;
        e_an  = (pc < GUARD) ? 8'hFF : ~(8'(1) << slot);
        e_seg = exp_digit(slot, blank_lz);
        e_ft  = ((t % FRAME) == FRAME - 1);
        if (clear)
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        if (display_wr) begin
            m_valid[display_idx] = 1'b1;
            m_val[display_idx]   = display_val;
        end
        t++;
        #1;
        check("an", {24'd0, an}, {24'd0, e_an});
        if (pc >= GUARD) begin
            check("seg", {25'd0, seg}, {25'd0, e_seg});
            obs_slot[slot] = seg;
        end
        check("frame_tick", {31'd0, frame_tick}, {31'd0, e_ft});
        if (frame_tick) ticks++;
    endtask

    task automatic idle(input int n);
        display_wr = 1'b0;
        clear      = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input logic [2:0] idx, input logic [3:0] val, input bit clr);
        display_idx = idx;
        display_val = val;
        display_wr  = 1'b1;
        clear       = clr;
        step();
        display_wr  = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic expect_slots(input string tag);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s_slot%0d", tag, k), {25'd0, obs_slot[k]}, {25'd0, want[k]});
    endtask

    task automatic do_reset(input bit chk_now);
        display_wr = 1'b0;
        clear      = 1'b0;
        rst        = 1'b0;
        if (chk_now) begin
            #1;
            check("rst_async_an", {24'd0, an}, 32'hFF);
            check("rst_async_seg", {25'd0, seg}, 32'h7F);
            check("rst_async_ft", {31'd0, frame_tick}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_an", {24'd0, an}, 32'hFF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_ft", {31'd0, frame_tick}, 32'd0);
        rst = 1'b1;
        t   = 0;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    initial begin
        logic [3:0] pat [8];
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_val[i]   = 4'd0;
        end
        display_val = '0;
        display_idx = '0;
        blank_lz    = 1'b0;
        do_reset(1'b0);

        // Idle scan: blank digits, one frame tick per 64 cycles
        ticks = 0;
        idle(2 * FRAME);
        check("idle_tick_count", ticks, 2);
        want = '{default: 7'h7F};
        expect_slots("idle");

        // Decode sweep
        for (int k = 0; k < 8; k++) write(3'(k), 4'(k + 1), 1'b0);
        idle(80);
        want = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
        expect_slots("sweep");

        // Leading-zero blanking
        do_clear();
        blank_lz = 1'b1;
        pat = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0};
        for (int k = 0; k < 8; k++) write(3'(k), pat[k], 1'b0);
        idle(80);
        want = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h40};
        expect_slots("lz_on");
        blank_lz = 1'b0;
        idle(80);
        want = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h40};
        expect_slots("lz_off");
        blank_lz = 1'b1;
        for (int k = 0; k < 8; k++) write(3'(k), 4'd0, 1'b0);
        idle(80);
        want = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        expect_slots("lz_allzero");

        // Error pattern
        do_clear();
        pat = '{4'hE, 4'hC, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int k = 0; k < 4; k++) write(3'(k), pat[k], 1'b0);
        idle(80);
        want = '{7'h06, 7'h46, 7'h46, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        expect_slots("err");

        // Clear together with a write
        blank_lz = 1'b0;
        for (int k = 0; k < 8; k++) write(3'(k), 4'd8, 1'b0);
        write(3'd3, 4'd9, 1'b1);
        idle(80);
        want = '{7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        expect_slots("clr_wr");

        // Reset during the drive phase of slot 5
        for (int k = 0; k < 8; k++) write(3'(k), 4'(k + 3), 1'b0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (((t - 1) % FRAME) / SCAN_DIV == 5 && ((t - 1) % SCAN_DIV) >= GUARD + 1) break;
            step();
        end
        check("pre_rst_an", {24'd0, an}, 32'hDF);
        do_reset(1'b1);
        idle(80);
        want = '{default: 7'h7F};
        expect_slots("post_rst");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            display_wr  = ($urandom_range(0, 1) == 1);
            display_idx = 3'($urandom_range(0, 7));
            display_val = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            clear       = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
            step();
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/display_mux8.md
# display_mux8

Downstream display stage of the calculator. Captures the digit writes the calculator core emits on its `display_val`/`display_idx`/`display_wr` interface into an 8-entry digit store. It then time-multiplexes the stored digits onto one common-anode 8-digit seven-segment display. The block owns the refresh prescaler, the digit scan, hex-to-segment decoding, anti-ghosting guard time and optional leading-zero blanking.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 4.
- `GUARD`, default 2: cycles at the start of each slot with all anodes off; legal range 1 ≤ GUARD < SCAN_DIV.
- `clk` input 1: single system clock; all logic is on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `display_val` input 4: digit value to store (0x0–0xF).
- `display_idx` input 3: digit position; 0 = leftmost (most significant), 7 = rightmost.
- `display_wr` input 1: write strobe; stores `display_val` at `display_idx` on this edge.
- `clear` input 1: synchronous; marks all 8 entries blank.
- `blank_lz` input 1: enables leading-zero blanking.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low.
- `an` output 8: digit anodes, active-low; bit k drives position k.
- `frame_tick` output 1: one-cycle pulse at each scan wrap.

## Operation
- **Digit store**
  - 8 entries, each {valid, value[3:0]}.
  - On `display_wr`, entry[`display_idx`] becomes {1, `display_val`}.
  - On `clear`, every entry becomes valid=0.
  - When `clear` and `display_wr` occur on the same edge, the clear is applied first and the write second: the written entry is valid and all others are blank.
  - Writes are accepted every cycle with no back-pressure. Back-to-back writes to the same index: the last write wins.
- **Prescaler**
  - `pc` counts 0..SCAN_DIV-1 and wraps to 0.
  - `scan` (3 bits) increments when `pc` == SCAN_DIV-1, wrapping 7→0.
- **Slot phases**, selected by `pc`:
  - GUARD (`pc` < GUARD): all anodes off.
  - DRIVE (`pc` ≥ GUARD): anode[`scan`] is on and `seg` shows entry[`scan`].
- **Decode** (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Blank = 7F.
- **Blanking**
  - An invalid entry displays blank.
  - When `blank_lz`=1, entry k is blanked if k ≠ 7, its value is 0, and every entry j < k is either invalid or has value 0.
  - Position 7 is never blanked by the leading-zero rule.
  - Non-zero values such as E and C terminate the leading-zero run.
- `frame_tick` pulses for the slot transition in which `scan` goes 7→0.

## Timing
- **Reset values:** `pc`=0, `scan`=0, all entries invalid, `seg`=7F, `an`=FF, `frame_tick`=0.
- `seg`, `an` and `frame_tick` are registered. Each reflects the `pc`/`scan`/store state of the previous cycle, giving one cycle of latency.
- A write at edge t to the currently driven position is visible on `seg` after edge t+1. The combinational blanking path must also settle within that one cycle.
- `frame_tick` is high for the single cycle following the edge on which `scan` wrapped 7→0.
- Full frame period = 8×SCAN_DIV cycles.
- `an` never has more than one bit low. `an` is FF during every guard phase, including the very first slot after reset.
- Reset asserted mid-frame immediately forces the reset values asynchronously. The scan restarts at slot 0, guard phase, on the first edge after release.
- `clear`/`blank_lz` changes take effect on displayed output with the same one-cycle latency.

## Test plan
All scenarios use SCAN_DIV=8, GUARD=2.

1. **Reset and idle scan.** Apply reset and release it, with no writes. Required: `seg`=7F throughout. `an` per slot is FF for 2 cycles then FE, FD, … 7F for 6 cycles. `frame_tick` pulses once every 64 cycles.
2. **Decode sweep.** Write values 1,2,3,4,5,6,7,8 to idx 0..7, one per cycle. Required: in the drive phase of slot k, `an`=~(1<<k) and `seg` equals the decode table value for k+1, e.g. slot 0 → 79, slot 7 → 00.
3. **Leading-zero blanking.** Write 0,0,0,0,0,1,2,0 to idx 0..7.
   - With `blank_lz`=1: slots 0–4 show 7F; slots 5,6,7 show 79, 24, 40.
   - With `blank_lz`=0: slots 0–4 show 40.
   - Writing all zeros with `blank_lz`=1 leaves only slot 7 showing 40.
4. **Error pattern.** Write E,C,C,0 to idx 0..3 with the rest blank and `blank_lz`=1. Required: slots 0–3 show 06, 46, 46, 40 and slots 4–7 show 7F.
5. **Clear with simultaneous write.** Fill all 8 entries with 8. Assert `clear` together with `display_wr` (idx 3, val 9). Required: only slot 3 shows 10; all other slots show 7F.
6. **Reset mid-frame.** Assert `rst` during the drive phase of slot 5. Required: `an`=FF and `seg`=7F immediately. After release, scanning resumes at slot 0 in the guard phase and the store is empty.
